// File: rtl/wave_pkg.sv
// Shared types for the pulse/square tone source: FSM states and the packed
// configuration word (enable, period, high-time, amplitude).
package wave_pkg;

  localparam int unsigned WIDTH_P    = 12;
  localparam int unsigned PERIOD_W_P = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  typedef struct packed {
    logic                  en;
    logic [PERIOD_W_P-1:0] period;
    logic [PERIOD_W_P-1:0] high;
    logic [WIDTH_P-2:0]    amp;
  } cfg_t;

endpackage

// File: rtl/pulse_phase_counter.sv
// Phase register: advances on request, wraps to 0 at limit-1, synchronous clear.
// Exposes the next phase and the wrap strobe combinationally for the parent.
module pulse_phase_counter #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [width_p-1:0] limit_i,
  output logic [width_p-1:0] phase_nxt_c_o,
  output logic               wrap_c_o
);

  logic [width_p-1:0] phase_q, phase_d;

  assign wrap_c_o = adv_i && (phase_q == (limit_i - width_p'(1)));

  always_comb begin
    phase_d = phase_q;
    if (clr_i || wrap_c_o) begin
      phase_d = '0;
    end else if (adv_i) begin
      phase_d = phase_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_nxt_c_o = phase_d;

endmodule

// File: rtl/pulse_wave_gen.sv
// Runtime-programmable pulse/square tone source on a ready/valid sample stream.
// New configs take effect only at a period boundary, so changes are glitch-free.
module pulse_wave_gen
  import wave_pkg::*;
#(
  parameter int unsigned width_p         = WIDTH_P,
  parameter int unsigned period_width_p  = PERIOD_W_P,
  parameter real         sampling_freq_p = 44100.0,
  parameter real         note_freq_p     = 440.0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic                      cfg_en_i,
  input  logic [period_width_p-1:0] cfg_period_i,
  input  logic [period_width_p-1:0] cfg_high_i,
  input  logic [width_p-2:0]        cfg_amp_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [width_p-1:0]        data_o
);

  localparam int unsigned RESET_PERIOD = $rtoi(sampling_freq_p / note_freq_p);

  localparam cfg_t RESET_CFG = '{
    en:     1'b1,
    period: PERIOD_W_P'(RESET_PERIOD),
    high:   PERIOD_W_P'(RESET_PERIOD / 2),
    amp:    {(WIDTH_P-1){1'b1}}
  };

  state_e             state_q, state_d;
  cfg_t               act_q, act_d;
  cfg_t               pend_q, pend_d;
  cfg_t               cfg_in;
  logic               valid_q;
  logic               cfg_ready_q, cfg_ready_d;
  logic [width_p-1:0] data_q, data_d;
  logic               hs, adv, cfg_acc, wrap, clr;
  logic [period_width_p-1:0] phase_nxt;

  // Period floor of 2; high-time saturates at the period (constant +amp).
  function automatic cfg_t clamp_cfg(input cfg_t c);
    cfg_t r;
    r = c;
    if (c.period < PERIOD_W_P'(2)) r.period = PERIOD_W_P'(2);
    if (r.high > r.period) r.high = r.period;
    return r;
  endfunction

  function automatic logic [width_p-1:0] sample_of(input cfg_t c,
                                                   input logic [period_width_p-1:0] ph);
    logic [width_p-1:0] mag;
    mag = width_p'(c.amp);
    if (!c.en)            return '0;
    else if (ph < c.high) return mag;
    else                  return -mag;
  endfunction

  assign cfg_in = '{en:     cfg_en_i,
                    period: PERIOD_W_P'(cfg_period_i),
                    high:   PERIOD_W_P'(cfg_high_i),
                    amp:    (WIDTH_P-1)'(cfg_amp_i)};

  assign hs      = valid_q & ready_i;
  assign adv     = hs & (state_q != ST_IDLE);
  assign cfg_acc = cfg_valid_i & cfg_ready_q;

  pulse_phase_counter #(
    .width_p (period_width_p)
  ) u_phase (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clr_i         (clr),
    .adv_i         (adv),
    .limit_i       (period_width_p'(act_q.period)),
    .phase_nxt_c_o (phase_nxt),
    .wrap_c_o      (wrap)
  );

  // Next-state logic: config capture, boundary apply and state transitions.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_acc) begin
          act_d   = clamp_cfg(cfg_in);
          clr     = 1'b1;
          state_d = cfg_in.en ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_acc && wrap) begin
          act_d   = clamp_cfg(cfg_in);
          clr     = 1'b1;
          state_d = cfg_in.en ? ST_RUN : ST_IDLE;
        end else if (cfg_acc) begin
          pend_d  = cfg_in;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          act_d   = clamp_cfg(pend_q);
          clr     = 1'b1;
          state_d = pend_q.en ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_RUN;
    endcase
    cfg_ready_d = (state_d != ST_PEND);
  end

  // Output sample is computed from next-cycle config and phase, then registered.
  assign data_d = sample_of(act_d, phase_nxt);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      act_q       <= RESET_CFG;
      pend_q      <= '0;
      valid_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      valid_q     <= 1'b1;
      cfg_ready_q <= cfg_ready_d;
      data_q      <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign cfg_ready_o = cfg_ready_q;
  assign data_o      = data_q;

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed + randomized bench for pulse_wave_gen against a sample-count model.
module tb_pulse_wave_gen;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic        cfg_en_i;
  logic [15:0] cfg_period_i;
  logic [15:0] cfg_high_i;
  logic [10:0] cfg_amp_i;
  logic        ready_i;
  logic        valid_o;
  logic [11:0] data_o;

  int checks = 0;
  int errors = 0;

  // Reference model: active config, optional pending config, samples taken in period.
  bit m_en;
  int m_per, m_high, m_amp, m_k;
  bit m_pend;
  bit p_en;
  int p_per, p_high, p_amp;
  bit m_valid, m_cfgrdy;

  pulse_wave_gen dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_en_i     (cfg_en_i),
    .cfg_period_i (cfg_period_i),
    .cfg_high_i   (cfg_high_i),
    .cfg_amp_i    (cfg_amp_i),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .data_o       (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b1; m_per = 100; m_high = 50; m_amp = 2047; m_k = 0;
    m_pend = 1'b0; m_valid = 1'b0; m_cfgrdy = 1'b0;
  endtask

  task automatic model_apply(input bit en, input int per, input int high, input int amp);
    m_en = en; m_per = (per < 2) ? 2 : per; m_high = high; m_amp = amp;
    m_k = 0; m_pend = 1'b0;
  endtask

  function automatic logic [11:0] exp_data();
    if (!m_en) return 12'd0;
    if (m_k < m_high) return 12'(m_amp);
    return 12'(-m_amp);
  endfunction

  // One clock: model the edge from current inputs, then compare all outputs.
  task automatic step(input bit rdy, input bit cv, output bit accepted);
    bit hs, acc, wrap;
    ready_i = rdy; cfg_valid_i = cv;
    @(posedge clk_i);
    hs   = rdy && m_valid;
    acc  = cv && m_cfgrdy;
    wrap = hs && m_en && (m_k == m_per - 1);
    if (!m_en) begin
      if (acc) model_apply(cfg_en_i, int'(cfg_period_i), int'(cfg_high_i), int'(cfg_amp_i));
    end else if (m_pend) begin
      if (wrap) model_apply(p_en, p_per, p_high, p_amp);
      else if (hs) m_k++;
    end else if (acc && wrap) begin
      model_apply(cfg_en_i, int'(cfg_period_i), int'(cfg_high_i), int'(cfg_amp_i));
    end else begin
      if (acc) begin
        m_pend = 1'b1; p_en = cfg_en_i; p_per = int'(cfg_period_i);
        p_high = int'(cfg_high_i); p_amp = int'(cfg_amp_i);
      end
      if (hs) m_k = wrap ? 0 : m_k + 1;
    end
    m_valid  = 1'b1;
    m_cfgrdy = !m_pend;
    accepted = acc;
    #1;
    chk("valid_o", 32'(valid_o), 32'(m_valid));
    chk("cfg_ready_o", 32'(cfg_ready_o), 32'(m_cfgrdy));
    chk("data_o", 32'(data_o), 32'(exp_data()));
    cfg_valid_i = 1'b0;
  endtask

  function automatic bit pick_ready(input int mode);
    if (mode == 2) return ($urandom_range(0, 99) < 40);
    return mode[0];
  endfunction

  task automatic run(input int n, input int mode);
    bit a;
    for (int i = 0; i < n; i++) step(pick_ready(mode), 1'b0, a);
  endtask

  // Offer a config until the model sees it accepted, with a cycle budget.
  task automatic offer(input bit en, input int per, input int high, input int amp,
                       input int mode);
    bit a;
    int n;
    cfg_en_i = en; cfg_period_i = 16'(per); cfg_high_i = 16'(high); cfg_amp_i = 11'(amp);
    a = 1'b0; n = 0;
    while (!a && n < 400) begin
      step(pick_ready(mode), 1'b1, a);
      n++;
    end
    if (!a) chk("offer_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    bit a;
    reset_i = 1'b1; cfg_valid_i = 1'b0; ready_i = 1'b0;
    cfg_en_i = 1'b0; cfg_period_i = '0; cfg_high_i = '0; cfg_amp_i = '0;
    model_reset();
    @(posedge clk_i); #1;
    chk("rst_valid", 32'(valid_o), 32'(0));
    chk("rst_data", 32'(data_o), 32'(0));
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'(0));
    reset_i = 1'b0;

    // Default 100-sample square at full scale.
    run(120, 1);
    // Mid-period reprogram; old period completes first.
    offer(1'b1, 10, 3, 100, 1);
    run(110, 1);
    // Randomized back-pressure at period 8, 50 % duty.
    offer(1'b1, 8, 4, 500, 2);
    run(80, 2);
    // Edge configs.
    offer(1'b1, 0, 1, 300, 2);
    run(30, 2);
    offer(1'b1, 10, 12, 700, 2);
    run(40, 2);
    offer(1'b1, 6, 0, 2047, 2);
    run(30, 2);
    offer(1'b1, 5, 2, 0, 2);
    run(30, 2);
    // Disable at the boundary, then re-enable from IDLE.
    offer(1'b0, 8, 4, 100, 2);
    run(20, 2);
    offer(1'b1, 6, 2, 900, 2);
    run(20, 2);
    // Capture a pending config without a wrap, then reset asynchronously.
    offer(1'b1, 20, 5, 50, 0);
    step(1'b0, 1'b0, a);
    #2 reset_i = 1'b1;
    #1;
    chk("async_valid", 32'(valid_o), 32'(0));
    chk("async_data", 32'(data_o), 32'(0));
    chk("async_cfg_ready", 32'(cfg_ready_o), 32'(0));
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    run(150, 1);
    run(40, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
